// File: rtl/iso_stream_serializer.sv
// Splits each source word into Ratio beats, LSB slice first, through a
// 2-entry word buffer so one word can be filled while the other drains.
module iso_stream_serializer #(
   parameter int DataWidth = 32,
   parameter int Ratio     = 4
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          src_valid_i,
   output logic                          src_ready_o,
   input  logic [DataWidth-1:0]          src_data_i,
   output logic                          dst_valid_o,
   input  logic                          dst_ready_i,
   output logic [DataWidth/Ratio-1:0]    dst_data_o,
   output logic                          dst_last_o,
   output logic [((Ratio <= 2) ? 1 : $clog2(Ratio))-1:0] dst_idx_o
);

   localparam int BeatWidth = DataWidth / Ratio;
   localparam int IdxWidth  = (Ratio <= 2) ? 1 : $clog2(Ratio);
   localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(Ratio - 1);

   if ((DataWidth % Ratio) != 0 || Ratio < 2) begin : g_bad_params
      $error("iso_stream_serializer: DataWidth must be a multiple of Ratio and Ratio >= 2");
   end

   logic [DataWidth-1:0] mem [2];
   logic [1:0]           rd, wr;
   logic [IdxWidth-1:0]  beat_q;
   logic [DataWidth-1:0] cur_word;
   logic                 src_hs, dst_hs, last_beat;

   // Pointers carry one extra bit so equal LSBs can mean either empty or full.
   assign src_ready_o = ((rd ^ wr) != 2'b10) && !rst_i;
   assign dst_valid_o = ((rd ^ wr) != 2'b00) && !rst_i;
   assign src_hs      = src_valid_i && src_ready_o;
   assign dst_hs      = dst_valid_o && dst_ready_i;
   assign last_beat   = (beat_q == LastIdx);

   assign cur_word    = mem[rd[0]] >> (32'(beat_q) * BeatWidth);
   assign dst_data_o  = cur_word[BeatWidth-1:0];
   assign dst_idx_o   = rst_i ? '0 : beat_q;
   assign dst_last_o  = dst_valid_o && last_beat;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd     <= 2'd0;
         wr     <= 2'd0;
         beat_q <= '0;
      end else begin
         if (src_hs) wr <= wr + 2'd1;
         if (dst_hs) begin
            if (last_beat) begin
               beat_q <= '0;
               rd     <= rd + 2'd1;
            end else begin
               beat_q <= beat_q + 1'b1;
            end
         end
      end
   end

   // src_ready only rises when an entry is free, so this never hits a live word.
   always_ff @(posedge clk_i) begin
      if (src_hs) mem[wr[0]] <= src_data_i;
   end

endmodule

// File: tb/tb_iso_stream_serializer.sv
// Randomized and directed bench for iso_stream_serializer (32-bit words, 4 beats)
// against a word-queue reference model.
module tb_iso_stream_serializer;

   logic        clk = 1'b0;
   logic        rst;
   logic        src_valid;
   logic        src_ready;
   logic [31:0] src_data;
   logic        dst_valid;
   logic        dst_ready;
   logic [7:0]  dst_data;
   logic        dst_last;
   logic [1:0]  dst_idx;

   int pass_cnt  = 0;
   int total_cnt = 0;
   bit chk_en    = 1'b0;

   // reference model: words held, and beats already sent from the head word
   logic [31:0] words[$];
   int          beat = 0;
   int          words_acc = 0;
   int          beats_out = 0;

   always #5 clk = ~clk;

   iso_stream_serializer #(.DataWidth(32), .Ratio(4)) dut (
      .clk_i(clk), .rst_i(rst),
      .src_valid_i(src_valid), .src_ready_o(src_ready), .src_data_i(src_data),
      .dst_valid_o(dst_valid), .dst_ready_i(dst_ready), .dst_data_o(dst_data),
      .dst_last_o(dst_last), .dst_idx_o(dst_idx)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // model update on the same edge the DUT samples
   always @(posedge clk) begin
      bit do_push, do_pop;
      if (rst) begin
         words.delete();
         beat = 0;
      end else begin
         do_push = src_valid && (words.size() < 2);
         do_pop  = dst_ready && (words.size() > 0);
         if (do_pop) begin
            beats_out++;
            if (beat == 3) begin
               void'(words.pop_front());
               beat = 0;
            end else beat++;
         end
         if (do_push) begin
            words.push_back(src_data);
            words_acc++;
         end
      end
   end

   // per-cycle comparison of every output against the model
   always @(negedge clk) begin
      logic [31:0] w;
      bit ev;
      if (chk_en) begin
         ev = !rst && (words.size() > 0);
         chk("src_ready", src_ready, !rst && (words.size() < 2));
         chk("dst_valid", dst_valid, ev);
         chk("dst_idx",   dst_idx,   rst ? 0 : beat);
         chk("dst_last",  dst_last,  ev && (beat == 3));
         if (ev) begin
            w = words[0];
            chk("dst_data", dst_data, w[beat*8 +: 8]);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic lit(input logic v, input logic [7:0] d, input logic [1:0] i, input logic l);
      chk("lit_valid", dst_valid, v);
      if (v) begin
         chk("lit_data", dst_data, d);
         chk("lit_idx",  dst_idx,  i);
         chk("lit_last", dst_last, l);
      end
   endtask

   task automatic drain();
      src_valid = 1'b0;
      dst_ready = 1'b1;
      for (int i = 0; i < 12; i++) cyc();
   endtask

   initial begin
      int cycles;
      rst = 1'b1; src_valid = 1'b0; src_data = '0; dst_ready = 1'b0;
      cyc();
      chk_en = 1'b1;
      cyc();
      chk("rst_src_ready", src_ready, 1'b0);
      chk("rst_dst_valid", dst_valid, 1'b0);
      rst = 1'b0;
      cyc();
      chk("rel_src_ready", src_ready, 1'b1);
      chk("rel_dst_valid", dst_valid, 1'b0);

      // single word
      src_valid = 1'b1; src_data = 32'hDDCCBBAA; dst_ready = 1'b1;
      cyc();
      src_valid = 1'b0;
      lit(1, 8'hAA, 0, 0); cyc();
      lit(1, 8'hBB, 1, 0); cyc();
      lit(1, 8'hCC, 2, 0); cyc();
      lit(1, 8'hDD, 3, 1); cyc();
      lit(0, 8'h00, 0, 0);

      // back-to-back words, no bubbles
      src_valid = 1'b1; src_data = 32'h03020100;
      chk("b2b_ready0", src_ready, 1'b1);
      cyc();
      lit(1, 8'h00, 0, 0);
      src_data = 32'h07060504;
      chk("b2b_ready1", src_ready, 1'b1);
      cyc();
      src_valid = 1'b0;
      for (int i = 1; i < 8; i++) begin
         lit(1, 8'(i), 2'(i % 4), (i % 4) == 3);
         cyc();
      end
      lit(0, 8'h00, 0, 0);

      // fill with the sink stalled
      dst_ready = 1'b0; src_valid = 1'b1; src_data = 32'hDDCCBBAA;
      cyc();
      src_data = 32'h44332211;
      cyc();
      src_data = 32'h88776655;
      chk("full_ready", src_ready, 1'b0);
      lit(1, 8'hAA, 0, 0);
      cyc();
      chk("full_ready2", src_ready, 1'b0);
      lit(1, 8'hAA, 0, 0);
      cyc();
      lit(1, 8'hAA, 0, 0);

      // final-beat pop while full: ready stays low, rises next cycle
      dst_ready = 1'b1;
      cyc(); cyc(); cyc();
      lit(1, 8'hDD, 3, 1);
      chk("fullpop_ready_lo", src_ready, 1'b0);
      cyc();
      chk("fullpop_ready_hi", src_ready, 1'b1);
      lit(1, 8'h11, 0, 0);
      cyc();
      src_valid = 1'b0;
      lit(1, 8'h22, 1, 0);
      chk("third_accepted", words_acc, 64'd6);
      drain();

      // reset in the middle of a word
      src_valid = 1'b1; src_data = 32'h0D0C0B0A; dst_ready = 1'b1;
      cyc();
      src_data = 32'h5A5A5A5A;
      cyc();
      src_valid = 1'b0;
      cyc();
      lit(1, 8'h0C, 2, 0);
      rst = 1'b1;
      cyc();
      chk("midrst_valid", dst_valid, 1'b0);
      chk("midrst_idx",   dst_idx,   2'd0);
      rst = 1'b0;
      cyc();
      chk("postrst_ready", src_ready, 1'b1);
      chk("postrst_valid", dst_valid, 1'b0);
      src_valid = 1'b1; src_data = 32'h1F1E1D1C;
      cyc();
      src_valid = 1'b0;
      lit(1, 8'h1C, 0, 0);
      drain();

      // random valid/ready traffic over 1000 words
      cycles = 0;
      words_acc = 0;
      while (words_acc < 1000 && cycles < 40000) begin
         src_valid = ($urandom_range(0, 9) < 7);
         src_data  = $urandom;
         dst_ready = ($urandom_range(0, 9) < 7);
         cyc();
         cycles++;
      end
      chk("random_words_done", words_acc >= 1000, 1'b1);
      drain();
      chk("drained_empty", words.size(), 64'd0);
      chk("drained_valid", dst_valid, 1'b0);

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/iso_stream_serializer.md
ISO_STREAM_SERIALIZER -- requirements
Module: iso_stream_serializer

Interface
REQ-001 SHALL have parameter DataWidth, default 32, width of the source word in bits.
REQ-002 SHALL have parameter Ratio, default 4, the number of destination beats per source word.
REQ-003 SHALL derive BeatWidth = DataWidth/Ratio and IdxWidth = max(1, $clog2(Ratio)).
REQ-004 SHALL have port clk_i, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_i, input, 1, the reset; it is synchronous and active-high.
REQ-006 SHALL have port src_valid_i, input, 1, the source word is valid.
REQ-007 SHALL have port src_ready_o, output, 1, the block accepts a source word.
REQ-008 SHALL have port src_data_i, input, DataWidth, the source word.
REQ-009 SHALL have port dst_valid_o, output, 1, the destination beat is valid.
REQ-010 SHALL have port dst_ready_i, input, 1, the destination accepts the beat.
REQ-011 SHALL have port dst_data_o, output, BeatWidth, the destination beat.
REQ-012 SHALL have port dst_last_o, output, 1, the current beat is the final beat of its word.
REQ-013 SHALL have port dst_idx_o, output, IdxWidth, the index of the current beat within its word.

Function
REQ-014 SHALL require DataWidth % Ratio == 0 and Ratio >= 2, enforced by an elaboration-time error.
REQ-015 SHALL buffer words in a 2-entry memory with 2-bit rd/wr pointers; the MSB distinguishes full from empty, and the LSB indexes the entry.
REQ-016 SHALL define a source handshake as src_valid_i && src_ready_o: write src_data_i to mem[wr[0]] and advance wr by 1 (mod 4).
REQ-017 SHALL drive src_ready_o = ((rd ^ wr) != 2'b10) && !rst_i, with no combinational path from dst_ready_i or src_valid_i.
REQ-018 SHALL drive dst_valid_o = ((rd ^ wr) != 2'b00) && !rst_i, with no combinational path from src_valid_i or dst_ready_i.
REQ-019 SHALL hold a beat counter beat_q in the range 0..Ratio-1 and drive dst_idx_o = beat_q.
REQ-020 SHALL drive dst_data_o = mem[rd[0]][beat_q*BeatWidth +: BeatWidth], sending the LSB slice first.
REQ-021 SHALL drive dst_last_o = dst_valid_o && (beat_q == Ratio-1).
REQ-022 SHALL, on a destination handshake when beat_q < Ratio-1, increment beat_q; rd SHALL be unchanged.
REQ-023 SHALL, on a destination handshake when beat_q == Ratio-1, set beat_q to 0 and advance rd by 1 (mod 4), freeing the entry.
REQ-024 SHALL present the first beat of a word accepted into an empty buffer one cycle after acceptance; the latency is 1.
REQ-025 SHALL allow a push and a final-beat pop in the same cycle; both take effect, and the occupancy is unchanged.
REQ-026 SHALL, when the buffer is full and the final beat pops, keep src_ready_o low in that cycle and raise it in the next cycle, with no ready bypass.
REQ-027 SHALL, with dst_ready_i held at 1 and the source always valid, sustain one beat per cycle with no bubbles between words.
REQ-028 SHALL wrap the pointers 3->0 without data loss and keep entry order FIFO.
REQ-029 SHALL hold dst_data_o, dst_idx_o and dst_last_o stable while dst_valid_o && !dst_ready_i.
REQ-030 SHALL not modify an occupied entry; a write only targets the free entry.

Reset
REQ-031 SHALL, on a clk_i edge with rst_i=1, set rd=0, wr=0 and beat_q=0; memory contents are not reset.
REQ-032 SHALL hold src_ready_o=0, dst_valid_o=0, dst_last_o=0 and dst_idx_o=0 while rst_i=1.
REQ-033 SHALL, after rst_i is released, drive src_ready_o=1 and dst_valid_o=0 in the first cycle.
REQ-034 SHALL, on a reset mid-word, discard all buffered words and the partial word, and emit no further beats of those words.

Verification (DataWidth=32, Ratio=4)
REQ-035 SHALL cover single word: push 0xDDCCBBAA with dst_ready=1 -> beats 0xAA,0xBB,0xCC,0xDD on cycles 1..4, idx 0..3, last only on 0xDD.
REQ-036 SHALL cover back-to-back: push 0x03020100 then 0x07060504 with dst_ready=1 -> 8 consecutive beats 0x00..0x07, no idle cycle, and src_ready never blocks the second push.
REQ-037 SHALL cover full: dst_ready=0, push 3 words -> the first 2 are accepted, src_ready=0 on the third, and dst_data holds 0xAA stable.
REQ-038 SHALL cover a full-buffer pop: a full buffer and a final-beat handshake -> src_ready=0 that cycle and 1 the next, and the third word is accepted.
REQ-039 SHALL cover random stalls: random valid/ready over 1000 words -> the scoreboard matches all beats in order, including pointer wrap.
REQ-040 SHALL cover reset at beat idx 2 -> the next cycle has dst_valid=0, src_ready=1 after release, and the next word starts at idx 0.
